// File: rtl/noc_pkg.sv
// Shared definitions for the route requester: flit-type codes, output-port
// indices, requester FSM state encoding and flit-type classifiers.
package noc_pkg;

  localparam logic [1:0] FLIT_BODY      = 2'b00;
  localparam logic [1:0] FLIT_HEAD      = 2'b01;
  localparam logic [1:0] FLIT_TAIL      = 2'b10;
  localparam logic [1:0] FLIT_HEAD_TAIL = 2'b11;

  localparam logic [1:0] PORT_E = 2'd0;
  localparam logic [1:0] PORT_W = 2'd1;
  localparam logic [1:0] PORT_N = 2'd2;
  localparam logic [1:0] PORT_S = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_FORWARD = 2'd2,
    ST_RELIEVE = 2'd3
  } state_e;

  function automatic logic is_head_type(input logic [1:0] flit_type);
    return (flit_type == FLIT_HEAD) || (flit_type == FLIT_HEAD_TAIL);
  endfunction

  function automatic logic is_last_type(input logic [1:0] flit_type);
    return (flit_type == FLIT_TAIL) || (flit_type == FLIT_HEAD_TAIL);
  endfunction

endpackage

// File: rtl/xy_route_compute.sv
// Combinational dimension-ordered (X then Y) route computation from a
// destination coordinate to an output-port index of this router.
module xy_route_compute
  import noc_pkg::*;
#(
  parameter int N             = 4,
  parameter int REQUEST_WIDTH = 2,
  parameter int ROUTER_ID     = 0,
  parameter int LOCAL_PORT    = 0,
  parameter int LOG2N         = (N > 1) ? $clog2(N) : 1
) (
  input  logic [LOG2N-1:0]         dest_x,
  input  logic [LOG2N-1:0]         dest_y,
  output logic [REQUEST_WIDTH-1:0] port_idx
);

  localparam logic [LOG2N-1:0] MY_X = LOG2N'(ROUTER_ID % N);
  localparam logic [LOG2N-1:0] MY_Y = LOG2N'(ROUTER_ID / N);

  // X is resolved fully before Y, so a packet never turns from Y back into X.
  always_comb begin
    port_idx = REQUEST_WIDTH'(LOCAL_PORT);
    if (dest_x > MY_X) begin
      port_idx = REQUEST_WIDTH'(PORT_E);
    end else if (dest_x < MY_X) begin
      port_idx = REQUEST_WIDTH'(PORT_W);
    end else if (dest_y > MY_Y) begin
      port_idx = REQUEST_WIDTH'(PORT_S);
    end else if (dest_y < MY_Y) begin
      port_idx = REQUEST_WIDTH'(PORT_N);
    end else begin
      port_idx = REQUEST_WIDTH'(LOCAL_PORT);
    end
  end

endmodule

// File: rtl/route_requester.sv
// Requesting side of the switch-control reservation protocol: route the head
// flit, reserve the output port, stream the packet, release after the tail.
// Optional ROUTE_STATS_EN adds saturating pkt_count / stall_count outputs.
module route_requester
  import noc_pkg::*;
#(
  parameter int N             = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int REQUEST_WIDTH = 2,
  parameter int ROUTER_ID     = 0,
  parameter int LOCAL_PORT    = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     vc_active,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     routeReserveRequestValid,
  output logic [REQUEST_WIDTH-1:0] routeReserveRequest,
  input  logic                     routeReserveStatus,
  output logic                     routeRelieve,
  output logic                     err_drop
`ifdef ROUTE_STATS_EN
  ,
  output logic [15:0]              pkt_count,
  output logic [15:0]              stall_count
`endif
);

  localparam int LOG2N = (N > 1) ? $clog2(N) : 1;

  state_e                   state_q, state_d;
  logic [REQUEST_WIDTH-1:0] port_q, port_d;
  logic [REQUEST_WIDTH-1:0] route_port_s;
  logic [1:0]               flit_type_s;

  logic                     in_ready_s;
  logic [DATA_WIDTH-1:0]    out_data_s;
  logic                     out_valid_s;
  logic                     req_valid_s;
  logic [REQUEST_WIDTH-1:0] req_port_s;
  logic                     relieve_s;
  logic                     err_drop_s;

  assign flit_type_s = in_data[DATA_WIDTH-1 -: 2];

  xy_route_compute #(
    .N            (N),
    .REQUEST_WIDTH(REQUEST_WIDTH),
    .ROUTER_ID    (ROUTER_ID),
    .LOCAL_PORT   (LOCAL_PORT),
    .LOG2N        (LOG2N)
  ) u_xy_route_compute (
    .dest_x  (in_data[LOG2N-1:0]),
    .dest_y  (in_data[2*LOG2N-1:LOG2N]),
    .port_idx(route_port_s)
  );

  // Next-state and output decode for the reservation protocol.
  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    in_ready_s  = 1'b0;
    out_data_s  = '0;
    out_valid_s = 1'b0;
    req_valid_s = 1'b0;
    req_port_s  = '0;
    relieve_s   = 1'b0;
    err_drop_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && is_head_type(flit_type_s)) begin
          port_d  = route_port_s;
          state_d = ST_REQUEST;
        end else if (in_valid) begin
          in_ready_s = 1'b1;
          err_drop_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQUEST: begin
        req_valid_s = vc_active;
        req_port_s  = port_q;
        if (routeReserveStatus && vc_active) begin
          state_d = ST_FORWARD;
        end else begin
          state_d = ST_REQUEST;
        end
      end
      ST_FORWARD: begin
        out_data_s  = in_data;
        out_valid_s = in_valid && vc_active;
        in_ready_s  = out_valid_s && out_ready;
        if (in_ready_s && is_last_type(flit_type_s)) begin
          state_d = ST_RELIEVE;
        end else begin
          state_d = ST_FORWARD;
        end
      end
      ST_RELIEVE: begin
        relieve_s = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and latched output port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      port_q  <= '0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
    end
  end

  // Reset forces IDLE, where only the orphan-drop path is input-driven; gate it too.
  assign in_ready                 = rst & in_ready_s;
  assign err_drop                 = rst & err_drop_s;
  assign out_data                 = out_data_s;
  assign out_valid                = out_valid_s;
  assign routeReserveRequestValid = req_valid_s;
  assign routeReserveRequest      = req_port_s;
  assign routeRelieve             = relieve_s;

`ifdef ROUTE_STATS_EN
  logic [15:0] pkt_count_q, pkt_count_d;
  logic [15:0] stall_count_q, stall_count_d;

  // Saturating packet and reservation-stall counters.
  always_comb begin
    pkt_count_d   = pkt_count_q;
    stall_count_d = stall_count_q;
    if ((state_q == ST_RELIEVE) && (pkt_count_q != 16'hFFFF)) begin
      pkt_count_d = pkt_count_q + 16'd1;
    end else begin
      pkt_count_d = pkt_count_q;
    end
    if ((state_q == ST_REQUEST) && !(routeReserveStatus && vc_active) &&
        (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_count_q   <= 16'd0;
      stall_count_q <= 16'd0;
    end else begin
      pkt_count_q   <= pkt_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign pkt_count   = pkt_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_route_requester.sv
// Directed self-checking bench for route_requester at router 5 (X=1, Y=1) of a 4x4 mesh.
module tb_route_requester;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int RW  = 2;
  localparam int RID = 5;
  localparam int LP  = 0;

  logic          clk = 1'b0;
  logic          rst;
  logic          vc_active;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          rr_valid;
  logic [RW-1:0] rr_port;
  logic          rr_status;
  logic          relieve;
  logic          err_drop;
`ifdef ROUTE_STATS_EN
  logic [15:0]   pkt_count;
  logic [15:0]   stall_count;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  route_requester #(
    .N(N), .DATA_WIDTH(DW), .REQUEST_WIDTH(RW), .ROUTER_ID(RID), .LOCAL_PORT(LP)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .vc_active               (vc_active),
    .in_data                 (in_data),
    .in_valid                (in_valid),
    .in_ready                (in_ready),
    .out_data                (out_data),
    .out_valid               (out_valid),
    .out_ready               (out_ready),
    .routeReserveRequestValid(rr_valid),
    .routeReserveRequest     (rr_port),
    .routeReserveStatus      (rr_status),
    .routeRelieve            (relieve),
    .err_drop                (err_drop)
`ifdef ROUTE_STATS_EN
    ,
    .pkt_count               (pkt_count),
    .stall_count             (stall_count)
`endif
  );

  task automatic test_reset();
    rst = 1'b1; vc_active = 1'b1; in_valid = 1'b1; in_data = 8'h05; out_ready = 1'b1; rr_status = 1'b1;
    #1 rst = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fails++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    n_checks++; if (err_drop !== 1'b0) begin n_fails++; $display("FAIL rst_err_drop got=%b exp=0", err_drop); end
    n_checks++; if (rr_valid !== 1'b0) begin n_fails++; $display("FAIL rst_rr_valid got=%b exp=0", rr_valid); end
    n_checks++; if (rr_port !== 2'd0) begin n_fails++; $display("FAIL rst_rr_port got=%0d exp=0", rr_port); end
    n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (out_data !== 8'h00) begin n_fails++; $display("FAIL rst_out_data got=%h exp=00", out_data); end
    n_checks++; if (relieve !== 1'b0) begin n_fails++; $display("FAIL rst_relieve got=%b exp=0", relieve); end
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0; rr_status = 1'b0; rst = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fails++; $display("FAIL rst_rel_in_ready got=%b exp=0", in_ready); end
  endtask

  // Scenario 1: HEAD to (3,1) routes East; grant withheld for 3 request cycles.
  task automatic test_xy_forward();
    @(negedge clk); in_valid = 1'b1; in_data = 8'h47; vc_active = 1'b1; out_ready = 1'b1; rr_status = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fails++; $display("FAIL t1_idle_in_ready got=%b exp=0", in_ready); end
    n_checks++; if (rr_valid !== 1'b0) begin n_fails++; $display("FAIL t1_idle_rr_valid got=%b exp=0", rr_valid); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_checks++; if (rr_valid !== 1'b1) begin n_fails++; $display("FAIL t1_req_valid[%0d] got=%b exp=1", i, rr_valid); end
      n_checks++; if (rr_port !== 2'd0) begin n_fails++; $display("FAIL t1_req_port[%0d] got=%0d exp=0", i, rr_port); end
      n_checks++; if (in_ready !== 1'b0) begin n_fails++; $display("FAIL t1_req_in_ready[%0d] got=%b exp=0", i, in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL t1_req_out_valid[%0d] got=%b exp=0", i, out_valid); end
    end
    @(negedge clk); rr_status = 1'b1; #1;
    n_checks++; if (rr_valid !== 1'b1) begin n_fails++; $display("FAIL t1_grant_rr_valid got=%b exp=1", rr_valid); end
    @(negedge clk); rr_status = 1'b0; #1;
    n_checks++; if (rr_valid !== 1'b0) begin n_fails++; $display("FAIL t1_fwd_rr_valid got=%b exp=0", rr_valid); end
    n_checks++; if (out_valid !== 1'b1) begin n_fails++; $display("FAIL t1_fwd_out_valid got=%b exp=1", out_valid); end
    n_checks++; if (out_data !== 8'h47) begin n_fails++; $display("FAIL t1_fwd_head got=%h exp=47", out_data); end
    n_checks++; if (in_ready !== 1'b1) begin n_fails++; $display("FAIL t1_fwd_in_ready got=%b exp=1", in_ready); end
    @(negedge clk); in_data = 8'h11; #1;
    n_checks++; if (out_data !== 8'h11) begin n_fails++; $display("FAIL t1_fwd_body got=%h exp=11", out_data); end
    n_checks++; if (relieve !== 1'b0) begin n_fails++; $display("FAIL t1_body_relieve got=%b exp=0", relieve); end
    @(negedge clk); in_data = 8'h8A; #1;
    n_checks++; if (out_data !== 8'h8A) begin n_fails++; $display("FAIL t1_fwd_tail got=%h exp=8a", out_data); end
    n_checks++; if (in_ready !== 1'b1) begin n_fails++; $display("FAIL t1_tail_in_ready got=%b exp=1", in_ready); end
    n_checks++; if (relieve !== 1'b0) begin n_fails++; $display("FAIL t1_tail_relieve got=%b exp=0", relieve); end
    @(negedge clk); in_valid = 1'b0; in_data = 8'h00; #1;
    n_checks++; if (relieve !== 1'b1) begin n_fails++; $display("FAIL t1_relieve got=%b exp=1", relieve); end
    n_checks++; if (in_ready !== 1'b0) begin n_fails++; $display("FAIL t1_relieve_in_ready got=%b exp=0", in_ready); end
    @(negedge clk); #1;
    n_checks++; if (relieve !== 1'b0) begin n_fails++; $display("FAIL t1_relieve_once got=%b exp=0", relieve); end
  endtask

  // Scenario 2: HEAD_TAIL to self, immediate grant; in_ready high exactly once.
  task automatic test_local();
    int rdy_cnt;
    rdy_cnt = 0;
    @(negedge clk); in_valid = 1'b1; in_data = 8'hC5; rr_status = 1'b1; #1;
    if (in_ready === 1'b1) rdy_cnt++;
    @(negedge clk); #1;
    if (in_ready === 1'b1) rdy_cnt++;
    n_checks++; if (rr_valid !== 1'b1) begin n_fails++; $display("FAIL t2_rr_valid got=%b exp=1", rr_valid); end
    n_checks++; if (rr_port !== 2'd0) begin n_fails++; $display("FAIL t2_rr_port got=%0d exp=0", rr_port); end
    @(negedge clk); rr_status = 1'b0; #1;
    if (in_ready === 1'b1) rdy_cnt++;
    n_checks++; if (out_data !== 8'hC5) begin n_fails++; $display("FAIL t2_out_data got=%h exp=c5", out_data); end
    @(negedge clk); in_valid = 1'b0; #1;
    if (in_ready === 1'b1) rdy_cnt++;
    n_checks++; if (relieve !== 1'b1) begin n_fails++; $display("FAIL t2_relieve got=%b exp=1", relieve); end
    @(negedge clk); #1;
    if (in_ready === 1'b1) rdy_cnt++;
    n_checks++; if (rdy_cnt !== 1) begin n_fails++; $display("FAIL t2_in_ready_cycles got=%0d exp=1", rdy_cnt); end
  endtask

  // X-first routing from (1,1) over a table of single-flit packets.
  task automatic test_routing();
    logic [7:0] vec [5];
    logic [1:0] exp [5];
    vec = '{8'hC4, 8'hCC, 8'hC1, 8'hC9, 8'hCF};
    exp = '{2'd1, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); in_valid = 1'b1; in_data = vec[k]; rr_status = 1'b1; #1;
      @(negedge clk); #1;
      n_checks++; if (rr_port !== exp[k]) begin n_fails++; $display("FAIL route_port[%h] got=%0d exp=%0d", vec[k], rr_port, exp[k]); end
      @(negedge clk); rr_status = 1'b0; #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fails++; $display("FAIL route_xfer[%h] got=%b exp=1", vec[k], in_ready); end
      @(negedge clk); in_valid = 1'b0; #1;
      n_checks++; if (relieve !== 1'b1) begin n_fails++; $display("FAIL route_relieve[%h] got=%b exp=1", vec[k], relieve); end
    end
  endtask

  // Scenario 3: 4-flit packet to (1,3)=South with out_ready toggling 1010.
  task automatic test_out_ready_toggle();
    logic [7:0] f [4];
    int         idx;
    logic       exp_rdy;
    f = '{8'h4D, 8'h21, 8'h32, 8'h9F};
    idx = 0;
    @(negedge clk); in_valid = 1'b1; in_data = f[0]; rr_status = 1'b1; out_ready = 1'b1; #1;
    @(negedge clk); #1;
    n_checks++; if (rr_port !== 2'd3) begin n_fails++; $display("FAIL t3_rr_port got=%0d exp=3", rr_port); end
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); rr_status = 1'b0; exp_rdy = (i % 2 == 0); out_ready = exp_rdy; in_data = f[idx]; #1;
      n_checks++; if (out_data !== f[idx]) begin n_fails++; $display("FAIL t3_data[%0d] got=%h exp=%h", i, out_data, f[idx]); end
      n_checks++; if (in_ready !== exp_rdy) begin n_fails++; $display("FAIL t3_in_ready[%0d] got=%b exp=%b", i, in_ready, exp_rdy); end
      n_checks++; if (relieve !== 1'b0) begin n_fails++; $display("FAIL t3_early_relieve[%0d] got=%b exp=0", i, relieve); end
      if (exp_rdy) idx++;
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1; #1;
    n_checks++; if (relieve !== 1'b1) begin n_fails++; $display("FAIL t3_relieve got=%b exp=1", relieve); end
  endtask

  // Scenario 4: orphan BODY and TAIL flits in IDLE are dropped.
  task automatic test_orphan();
    @(negedge clk); in_valid = 1'b1; in_data = 8'h03; #1;
    n_checks++; if (err_drop !== 1'b1) begin n_fails++; $display("FAIL t4_body_err got=%b exp=1", err_drop); end
    n_checks++; if (in_ready !== 1'b1) begin n_fails++; $display("FAIL t4_body_ready got=%b exp=1", in_ready); end
    @(negedge clk); in_data = 8'h80; #1;
    n_checks++; if (err_drop !== 1'b1) begin n_fails++; $display("FAIL t4_tail_err got=%b exp=1", err_drop); end
    @(negedge clk); in_valid = 1'b0; #1;
    n_checks++; if (err_drop !== 1'b0) begin n_fails++; $display("FAIL t4_err_clear got=%b exp=0", err_drop); end
    n_checks++; if (rr_valid !== 1'b0) begin n_fails++; $display("FAIL t4_no_request got=%b exp=0", rr_valid); end
  endtask

  // Scenario 5: vc_active low stalls both REQUEST and FORWARD.
  task automatic test_vc_stall();
    @(negedge clk); in_valid = 1'b1; in_data = 8'h44; vc_active = 1'b1; rr_status = 1'b0; #1;
    @(negedge clk); vc_active = 1'b0; rr_status = 1'b1; #1;
    n_checks++; if (rr_valid !== 1'b0) begin n_fails++; $display("FAIL t5_req_vc0 got=%b exp=0", rr_valid); end
    @(negedge clk); #1;
    n_checks++; if (rr_valid !== 1'b0) begin n_fails++; $display("FAIL t5_req_vc0_hold got=%b exp=0", rr_valid); end
    @(negedge clk); vc_active = 1'b1; rr_status = 1'b0; #1;
    n_checks++; if (rr_valid !== 1'b1) begin n_fails++; $display("FAIL t5_req_resume got=%b exp=1", rr_valid); end
    n_checks++; if (rr_port !== 2'd1) begin n_fails++; $display("FAIL t5_req_port got=%0d exp=1", rr_port); end
    @(negedge clk); rr_status = 1'b1; #1;
    @(negedge clk); rr_status = 1'b0; vc_active = 1'b0; #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL t5_fwd_vc0_valid got=%b exp=0", out_valid); end
    n_checks++; if (in_ready !== 1'b0) begin n_fails++; $display("FAIL t5_fwd_vc0_ready got=%b exp=0", in_ready); end
    @(negedge clk); #1;
    n_checks++; if (rr_valid !== 1'b0) begin n_fails++; $display("FAIL t5_fwd_no_rereq got=%b exp=0", rr_valid); end
    @(negedge clk); vc_active = 1'b1; #1;
    n_checks++; if (out_valid !== 1'b1) begin n_fails++; $display("FAIL t5_fwd_resume got=%b exp=1", out_valid); end
    n_checks++; if (out_data !== 8'h44) begin n_fails++; $display("FAIL t5_fwd_data got=%h exp=44", out_data); end
    @(negedge clk); in_data = 8'h99; #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fails++; $display("FAIL t5_tail_ready got=%b exp=1", in_ready); end
    @(negedge clk); in_valid = 1'b0; #1;
    n_checks++; if (relieve !== 1'b1) begin n_fails++; $display("FAIL t5_relieve got=%b exp=1", relieve); end
  endtask

  // Next head waits through RELIEVE and one IDLE cycle before requesting.
  task automatic test_back_to_back();
    @(negedge clk); in_valid = 1'b1; in_data = 8'hC4; rr_status = 1'b1; #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fails++; $display("FAIL b2b_first_xfer got=%b exp=1", in_ready); end
    @(negedge clk); in_data = 8'hC1; #1;
    n_checks++; if (relieve !== 1'b1) begin n_fails++; $display("FAIL b2b_relieve got=%b exp=1", relieve); end
    n_checks++; if (rr_valid !== 1'b0) begin n_fails++; $display("FAIL b2b_relieve_req got=%b exp=0", rr_valid); end
    n_checks++; if (in_ready !== 1'b0) begin n_fails++; $display("FAIL b2b_relieve_ready got=%b exp=0", in_ready); end
    @(negedge clk); #1;
    n_checks++; if (rr_valid !== 1'b0) begin n_fails++; $display("FAIL b2b_idle_req got=%b exp=0", rr_valid); end
    n_checks++; if (in_ready !== 1'b0) begin n_fails++; $display("FAIL b2b_idle_ready got=%b exp=0", in_ready); end
    @(negedge clk); #1;
    n_checks++; if (rr_valid !== 1'b1) begin n_fails++; $display("FAIL b2b_second_req got=%b exp=1", rr_valid); end
    n_checks++; if (rr_port !== 2'd2) begin n_fails++; $display("FAIL b2b_second_port got=%0d exp=2", rr_port); end
    @(negedge clk); rr_status = 1'b0; #1;
    @(negedge clk); in_valid = 1'b0; #1;
    n_checks++; if (relieve !== 1'b1) begin n_fails++; $display("FAIL b2b_second_relieve got=%b exp=1", relieve); end
  endtask

  // Scenario 6: asynchronous reset in FORWARD abandons the packet.
  task automatic test_reset_mid();
    @(negedge clk); in_valid = 1'b1; in_data = 8'h47; rr_status = 1'b1; #1;
    @(negedge clk); #1;
    @(negedge clk); rr_status = 1'b0; #1;
    n_checks++; if (out_valid !== 1'b1) begin n_fails++; $display("FAIL t6_pre_out_valid got=%b exp=1", out_valid); end
    #1 rst = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL t6_async_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (out_data !== 8'h00) begin n_fails++; $display("FAIL t6_async_out_data got=%h exp=00", out_data); end
    n_checks++; if (in_ready !== 1'b0) begin n_fails++; $display("FAIL t6_async_in_ready got=%b exp=0", in_ready); end
    n_checks++; if (relieve !== 1'b0) begin n_fails++; $display("FAIL t6_async_relieve got=%b exp=0", relieve); end
    @(negedge clk); rst = 1'b1; in_data = 8'hC4; #1;
    n_checks++; if (rr_valid !== 1'b0) begin n_fails++; $display("FAIL t6_idle_req got=%b exp=0", rr_valid); end
    n_checks++; if (relieve !== 1'b0) begin n_fails++; $display("FAIL t6_no_relieve got=%b exp=0", relieve); end
    @(negedge clk); rr_status = 1'b1; #1;
    n_checks++; if (rr_valid !== 1'b1) begin n_fails++; $display("FAIL t6_restart_req got=%b exp=1", rr_valid); end
    n_checks++; if (rr_port !== 2'd1) begin n_fails++; $display("FAIL t6_restart_port got=%0d exp=1", rr_port); end
    @(negedge clk); rr_status = 1'b0; #1;
    @(negedge clk); in_valid = 1'b0; #1;
    n_checks++; if (relieve !== 1'b1) begin n_fails++; $display("FAIL t6_relieve got=%b exp=1", relieve); end
  endtask

  initial begin
    test_reset();
    test_xy_forward();
    test_local();
    test_routing();
    test_out_ready_toggle();
    test_orphan();
    test_vc_stall();
    test_back_to_back();
    test_reset_mid();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
